serial_shift_register: RTL and testbench

// - Serial-in, serial-out / parallel-out (SISO/SIPO) shift register.
// - One bit is shifted in per clock from sin.
// - The whole register is visible on pout; the oldest bit leaves on sout.
// - Generic datapath leaf: serial-to-parallel conversion, bit delay lines,

---
 rtl/shift_reg_pkg.sv | 24 ++
 rtl/shift_stage.sv | 37 +++
 rtl/serial_shift_register.sv | 66 ++++++
 tb/tb_serial_shift_register.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// shift_reg_pkg
//
// Shared constants for the serial shift register slice.
//   SHIFT_RIGHT / SHIFT_LEFT : encodings of the SHIFT_DIR parameter
//   DEFAULT_WIDTH            : register length used when none is given
//   sout_index()             : which register bit holds the oldest sample
// ---------------------------------------------------------------------------
package shift_reg_pkg;

    // sin enters the MSB and data moves toward the LSB.
    localparam logic SHIFT_RIGHT = 1'b0;
    // sin enters the LSB and data moves toward the MSB.
    localparam logic SHIFT_LEFT  = 1'b1;

    localparam int DEFAULT_WIDTH = 4;

    // The oldest bit always sits at the far end from where sin enters, so the
    // serial output tap depends only on the direction and the length.
    function automatic int sout_index(input int width, input logic dir);
        return (dir == SHIFT_LEFT) ? (width - 1) : 0;
    endfunction

endpackage : shift_reg_pkg

// File: rtl/shift_stage.sv
// ---------------------------------------------------------------------------
// shift_stage
//
// One bit of the shift register: a D flop with synchronous active-high reset.
//   clk : clock, rising edge
//   rst : synchronous reset, loads RESET_VAL
//   d   : next bit value when not in reset
//   q   : stored bit
// ---------------------------------------------------------------------------
module shift_stage #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic bit_d;
    logic bit_q;

    // Reset wins over the data input; d is ignored on a reset edge.
    always_comb begin
        bit_d = d;
        if (rst) begin
            bit_d = RESET_VAL;
        end
    end

    // Single storage flop for this stage.
    always_ff @(posedge clk) begin
        bit_q <= bit_d;
    end

    assign q = bit_q;

endmodule : shift_stage

// File: rtl/serial_shift_register.sv
// ---------------------------------------------------------------------------
// serial_shift_register
//
// Serial-in, serial-out / parallel-out shift register. One bit of sin is
// shifted in on every rising clk edge; the full contents appear on pout and
// the oldest bit appears on sout.
//
// Parameters:
//   WIDTH     : register length in bits (>= 2)
//   SHIFT_DIR : SHIFT_RIGHT (sin -> MSB, sout = LSB) or
//               SHIFT_LEFT  (sin -> LSB, sout = MSB)
//   RESET_VAL : value loaded on a reset edge
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, has priority over shifting
//   sin  : serial input, sampled every edge
//   sout : serial output, combinational tap of the oldest register bit
//   pout : parallel view of the register
// ---------------------------------------------------------------------------
module serial_shift_register
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic             SHIFT_DIR = SHIFT_RIGHT,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    output logic             sout,
    output logic [WIDTH-1:0] pout
);

    localparam int SOUT_IDX = sout_index(WIDTH, SHIFT_DIR);

    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] shreg;

    // Next register contents for a plain shift. The bit at the far end is
    // simply dropped; the stages apply reset themselves.
    always_comb begin
        shift_d = '0;
        if (SHIFT_DIR == SHIFT_LEFT) begin
            shift_d = {shreg[WIDTH-2:0], sin};
        end else begin
            shift_d = {sin, shreg[WIDTH-1:1]};
        end
    end

    // One flop per bit, each with its own slice of the reset value.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        shift_stage #(
            .RESET_VAL (RESET_VAL[i])
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .d   (shift_d[i]),
            .q   (shreg[i])
        );
    end

    assign pout = shreg;
    assign sout = shreg[SOUT_IDX];

endmodule : serial_shift_register

// File: tb/tb_serial_shift_register.sv
// ---------------------------------------------------------------------------
// tb_serial_shift_register
//
// Three instances share one clock:
//   a : WIDTH 4, shift right
//   b : WIDTH 4, shift left
//   c : WIDTH 8, shift right
// Each has a reference model holding the sampled history of sin, newest first.
// ---------------------------------------------------------------------------
module tb_serial_shift_register;

    logic       clk;
    logic       rst_a, sin_a, sout_a;
    logic       rst_b, sin_b, sout_b;
    logic       rst_c, sin_c, sout_c;
    logic [3:0] pout_a;
    logic [3:0] pout_b;
    logic [7:0] pout_c;

    int n_tests;
    int n_fail;

    // Newest sample at index 0; the last entry is the oldest bit (sout).
    logic hist_a[$];
    logic hist_b[$];
    logic hist_c[$];

    serial_shift_register #(.WIDTH(4), .SHIFT_DIR(1'b0), .RESET_VAL(4'b0000)) dut_a (
        .clk (clk), .rst (rst_a), .sin (sin_a), .sout (sout_a), .pout (pout_a)
    );

    serial_shift_register #(.WIDTH(4), .SHIFT_DIR(1'b1), .RESET_VAL(4'b0000)) dut_b (
        .clk (clk), .rst (rst_b), .sin (sin_b), .sout (sout_b), .pout (pout_b)
    );

    serial_shift_register #(.WIDTH(8), .SHIFT_DIR(1'b0), .RESET_VAL(8'h00)) dut_c (
        .clk (clk), .rst (rst_c), .sin (sin_c), .sout (sout_c), .pout (pout_c)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the history of one register by one edge.
    task automatic model_edge(inout logic hist[$], input int w, input logic r, input logic s);
        if (r) begin
            hist.delete();
            for (int k = 0; k < w; k++) hist.push_back(1'b0);
        end else begin
            hist.push_front(s);
            while (hist.size() > w) void'(hist.pop_back());
        end
    endtask

    // Parallel view of a history: for a right shift the newest bit is the
    // MSB, for a left shift the newest bit is the LSB.
    function automatic logic [7:0] exp_pout(input logic hist[$], input int w, input logic dir);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < w; k++) begin
            if (dir) r[k] = hist[k];
            else     r[w-1-k] = hist[k];
        end
        return r;
    endfunction

    // One rising edge; inputs are already stable, outputs are read 1 later.
    task automatic tick();
        @(posedge clk);
        model_edge(hist_a, 4, rst_a, sin_a);
        model_edge(hist_b, 4, rst_b, sin_b);
        model_edge(hist_c, 8, rst_c, sin_c);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; sin_a = 1'b1;
        rst_b = 1'b1; sin_b = 1'b1;
        rst_c = 1'b1; sin_c = 1'b1;
        tick();
        n_tests++;
        if (pout_a !== 4'b0000 || sout_a !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_a got pout=%b sout=%b want pout=0000 sout=0", pout_a, sout_a);
        end
        n_tests++;
        if (pout_b !== 4'b0000 || sout_b !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_b got pout=%b sout=%b want pout=0000 sout=0", pout_b, sout_b);
        end
        n_tests++;
        if (pout_c !== 8'h00 || sout_c !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_c got pout=%b sout=%b want pout=00000000 sout=0", pout_c, sout_c);
        end
    endtask

    task automatic test_serial_load();
        logic       bits[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] pexp[4]  = '{4'b1000, 4'b0100, 4'b0010, 4'b1001};
        logic       sexp[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        rst_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sin_a = bits[i];
            tick();
            n_tests++;
            if (pout_a !== pexp[i] || sout_a !== sexp[i]) begin
                n_fail++;
                $display("[TB] FAIL load[%0d] got pout=%b sout=%b want pout=%b sout=%b",
                         i, pout_a, sout_a, pexp[i], sexp[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [3:0] pexp[4] = '{4'b0100, 4'b0010, 4'b0001, 4'b0000};
        logic       sexp[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        rst_a = 1'b0;
        sin_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (pout_a !== pexp[i] || sout_a !== sexp[i]) begin
                n_fail++;
                $display("[TB] FAIL flush[%0d] got pout=%b sout=%b want pout=%b sout=%b",
                         i, pout_a, sout_a, pexp[i], sexp[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        rst_a = 1'b0;
        sin_a = 1'b1;
        repeat (3) tick();
        rst_a = 1'b1;
        sin_a = 1'b1;
        tick();
        n_tests++;
        if (pout_a !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL mid_reset got pout=%b want 0000", pout_a);
        end
        rst_a = 1'b0;
        sin_a = 1'b1;
        tick();
        n_tests++;
        if (pout_a !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL after_mid_reset got pout=%b want 1000", pout_a);
        end
    endtask

    task automatic test_shift_left();
        logic       bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] pexp[4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sin_b = bits[i];
            tick();
            n_tests++;
            if (pout_b !== pexp[i] || sout_b !== pexp[i][3]) begin
                n_fail++;
                $display("[TB] FAIL left[%0d] got pout=%b sout=%b want pout=%b sout=%b",
                         i, pout_b, sout_b, pexp[i], pexp[i][3]);
            end
        end
    endtask

    task automatic test_walking_one();
        rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        sin_c = 1'b1;
        tick();
        sin_c = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            n_tests++;
            if (sout_c !== (j == 7)) begin
                n_fail++;
                $display("[TB] FAIL walk_sout[+%0d] got %b want %b", j, sout_c, (j == 7));
            end
        end
        n_tests++;
        if (pout_c !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL walk_gone got pout=%b want 00000000", pout_c);
        end
    endtask

    task automatic test_random();
        logic [7:0] ea, eb, ec;
        for (int i = 0; i < 300; i++) begin
            rst_a = ($urandom_range(15) == 0);
            rst_b = ($urandom_range(15) == 0);
            rst_c = ($urandom_range(31) == 0);
            sin_a = 1'($urandom);
            sin_b = 1'($urandom);
            sin_c = 1'($urandom);
            tick();
            ea = exp_pout(hist_a, 4, 1'b0);
            eb = exp_pout(hist_b, 4, 1'b1);
            ec = exp_pout(hist_c, 8, 1'b0);
            n_tests++;
            if (pout_a !== ea[3:0] || sout_a !== hist_a[3]) begin
                n_fail++;
                $display("[TB] FAIL rand_a[%0d] got pout=%b sout=%b want pout=%b sout=%b",
                         i, pout_a, sout_a, ea[3:0], hist_a[3]);
            end
            n_tests++;
            if (pout_b !== eb[3:0] || sout_b !== hist_b[3]) begin
                n_fail++;
                $display("[TB] FAIL rand_b[%0d] got pout=%b sout=%b want pout=%b sout=%b",
                         i, pout_b, sout_b, eb[3:0], hist_b[3]);
            end
            n_tests++;
            if (pout_c !== ec || sout_c !== hist_c[7]) begin
                n_fail++;
                $display("[TB] FAIL rand_c[%0d] got pout=%b sout=%b want pout=%b sout=%b",
                         i, pout_c, sout_c, ec, hist_c[7]);
            end
        end
    endtask

    // Scenario sequence; inputs are changed 1 unit after each rising edge.
    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_a = 1'b1; sin_a = 1'b0;
        rst_b = 1'b1; sin_b = 1'b0;
        rst_c = 1'b1; sin_c = 1'b0;
        @(negedge clk);
        test_reset();
        test_serial_load();
        test_flush();
        test_mid_reset();
        test_shift_left();
        test_walking_one();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_shift_register
